wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between the in-order pipeline writeback stage and one long-latency requester (load-return / mul-div unit).
- The pipeline always has priority. Long-latency results queue in a small FIFO and drain on free cycles.
- A starvation counter requests a one-cycle pipeline stall when the queue is not draining.
- A busy bitmap is exported to issue logic for hazard checks.

Parameters:
- XLEN, 32, data width of register writes.
- DEPTH, 4, ext FIFO entries; power of two, >= 2.
- STARVE_MAX, 8, consecutive non-draining cycles with a non-empty FIFO before stall_o asserts; >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- pipe_valid_i  input  1  writeback-stage register write request; no backpressure.
- pipe_rdnum_i  input  5  destination register.
- pipe_rddata_i  input  XLEN  write data.
- ext_valid_i  input  1  long-latency result valid.
- ext_ready_o  output  1  FIFO can accept; equals !full.
- ext_rdnum_i  input  5  destination register.
- ext_rddata_i  input  XLEN  write data.
- stall_o  output  1  request that the pipeline hold writeback for one cycle.
- busy_o  output  32  bit r set while any queued FIFO entry targets register r.
- rf_we_o  output  1  register-file write enable (registered).
- rf_waddr_o  output  5  write address (registered).
- rf_wdata_o  output  XLEN  write data (registered).

Behaviour:
- Reset: while rst is low, FIFO is empty; rf_we_o, rf_waddr_o, rf_wdata_o, stall_o and the starvation counter are 0; busy_o is 0 and ext_ready_o is 1. Reset asserted mid-operation discards all queued entries with no write issued.
- Pipe path: if pipe_valid_i and pipe_rdnum_i != 0 at edge t, then rf_we/waddr/wdata reflect it after edge t. Latency is 1 cycle.
- Pipe writes to x0: consume the slot (FIFO does not pop), rf_we_o = 0.
- Ext accept: a handshake occurs when ext_valid_i && ext_ready_o.
  - ext_ready_o = !full, computed from the current count only. A same-cycle pop does not free a slot.
  - An accepted entry with rdnum 0 is dropped and not enqueued.
- Ext drain: when pipe_valid_i = 0 and the FIFO is non-empty, the head pops and is registered to the rf outputs.
  - Earliest write for an ext result is 2 edges after acceptance: enqueue at t, pop and register at t+1.
- Simultaneous push and pop: both occur and the count is unchanged. Push and pop pointers wrap modulo DEPTH.
- Ordering: FIFO entries commit in acceptance order. Ordering relative to pipe writes is not enforced. Issue logic uses busy_o to prevent WAW/RAW against queued registers.
- busy_o: OR over valid FIFO entries of a one-hot decode of their rdnum.
  - A bit clears the cycle after its last entry pops.
  - An entry being pushed sets its bit the cycle after acceptance.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- stall_o: registered; high for exactly one cycle after the counter reaches STARVE_MAX, then the counter clears.
  - If pipe_valid_i is still high during stall_o, the pipe still wins; the counter restarts from 0.
- Output hold: rf_we_o drops to 0 on any cycle with no grant. waddr and wdata hold their last values.

Test Plan:
- Pipe-only: pipe_valid=1, rd=5, data=0xDEADBEEF at edge t -> rf_we=1, waddr=5, wdata=0xDEADBEEF after t; the next idle cycle gives rf_we=0. Pipe rd=0 -> rf_we stays 0.
- Ext latency and busy: ext write rd=7, data=0x11 accepted at t, pipe idle -> busy_o[7]=1 after t; rf write of 7/0x11 after t+1; busy_o[7]=0 after t+1.
- Full FIFO (DEPTH=4):
  - Pipe valid continuously; 4 ext writes rd=1..4 -> ext_ready_o=0 after the 4th; a 5th offer is not accepted.
  - Then pipe idles -> writes rd 1,2,3,4 in order on consecutive cycles; ext_ready_o returns 1 after the first pop.
- Starvation: pipe_valid held 1 with 1 queued entry -> stall_o=1 for one cycle after 8 non-draining cycles.
  - Pipe drops valid that cycle -> entry drains and the counter is 0.
  - Repeat with pipe kept high -> stall_o re-asserts 8 cycles later.
- x0 and simultaneous events:
  - Ext rd=0 accepted -> FIFO count unchanged, no rf write.
  - Push and pop in the same cycle at count 2 -> count stays 2.
- Reset mid-drain: assert rst low with 3 queued entries -> busy_o=0, rf_we_o=0, ext_ready_o=1 immediately (asynchronous); no writes after release.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, long-latency return path,
// and the arbitrated register-file write, plus stall/busy feedback to issue.
interface wb_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            pipe_valid_i;
    logic [4:0]      pipe_rdnum_i;
    logic [XLEN-1:0] pipe_rddata_i;
    logic            ext_valid_i;
    logic            ext_ready_o;
    logic [4:0]      ext_rdnum_i;
    logic [XLEN-1:0] ext_rddata_i;
    logic            stall_o;
    logic [31:0]     busy_o;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;

    modport slave (
        input  pipe_valid_i, pipe_rdnum_i, pipe_rddata_i,
        input  ext_valid_i, ext_rdnum_i, ext_rddata_i,
        output ext_ready_o, stall_o, busy_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport master (
        output pipe_valid_i, pipe_rdnum_i, pipe_rddata_i,
        output ext_valid_i, ext_rdnum_i, ext_rddata_i,
        input  ext_ready_o, stall_o, busy_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, long-latency
// results queue in a small FIFO, drain on idle cycles, and a starvation stall.
module wb_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    wb_port_arbiter_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [4:0]      fifo_rd_d   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [XLEN-1:0] fifo_data_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            stall_q, stall_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic            full, empty, push, pop;
    logic [31:0]     busy;
    logic [PW-1:0]   busy_idx;

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
        push  = bus.ext_valid_i && !full && (bus.ext_rdnum_i != 5'd0);
        pop   = !bus.pipe_valid_i && !empty;

        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;

        if (push) begin
            fifo_rd_d[wr_ptr_q]   = bus.ext_rdnum_i;
            fifo_data_d[wr_ptr_q] = bus.ext_rddata_i;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (bus.pipe_valid_i) begin
            if (bus.pipe_rdnum_i != 5'd0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = bus.pipe_rdnum_i;
                rf_wdata_d = bus.pipe_rddata_i;
            end
        end else if (pop) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = fifo_rd_q[rd_ptr_q];
            rf_wdata_d = fifo_data_q[rd_ptr_q];
        end

        // A stall cycle restarts the count whether or not the pipe yielded.
        if (empty || pop || stall_q) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
        stall_d = (starve_d == SW'(STARVE_MAX));
    end

    always_comb begin
        busy     = '0;
        busy_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                busy[fifo_rd_q[busy_idx]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            stall_q     <= stall_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    assign bus.ext_ready_o = !full;
    assign bus.busy_o      = busy;
    assign bus.stall_o     = stall_q;
    assign bus.rf_we_o     = rf_we_q;
    assign bus.rf_waddr_o  = rf_waddr_q;
    assign bus.rf_wdata_o  = rf_wdata_q;
endmodule
